// File: rtl/compare1024_feeder_pkg.sv
// compare1024_feeder_pkg: shared state encoding, comparator mode codes and size helpers
package compare1024_feeder_pkg;
  localparam int CMP_BITS = 1024;
  typedef enum logic [1:0] {IDLE, STREAM, CAPTURE, DONE} state_t;
  localparam logic [1:0] MODE_NONE = 2'b00;
  localparam logic [1:0] MODE_XLT  = 2'b10;
  localparam logic [1:0] MODE_XGT  = 2'b01;
  localparam logic [1:0] MODE_EQ   = 2'b11;
  function automatic int nwords(input int iw);
    return CMP_BITS / iw;
  endfunction
endpackage

// File: rtl/compare1024_opbuf.sv
// compare1024_opbuf: X/Y operand buffers, one write port, registered paired read
module compare1024_opbuf #(
  parameter int IW = 32,
  parameter int NWORDS = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          we,
  input  logic          sel,
  input  logic [AW-1:0] waddr,
  input  logic [IW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [IW-1:0] rd_x,
  output logic [IW-1:0] rd_y
);
  logic [IW-1:0] mem_x [NWORDS];
  logic [IW-1:0] mem_y [NWORDS];
  // write-first forwarding so a word written on the start edge is streamed
  always_ff @(posedge clk) begin
    if (we && !sel) mem_x[waddr] <= wdata;
    if (we && sel) mem_y[waddr] <= wdata;
    rd_x <= (we && !sel && waddr == raddr) ? wdata : mem_x[raddr];
    rd_y <= (we && sel && waddr == raddr) ? wdata : mem_y[raddr];
  end
endmodule

// File: rtl/compare1024_feeder.sv
// compare1024_feeder: streams buffered 1024-bit operands into the comparator and latches its mode
module compare1024_feeder
  import compare1024_feeder_pkg::*;
#(
  parameter int IW = 32,
  parameter int NWORDS = nwords(IW),
  parameter int AW = $clog2(NWORDS),
  parameter int TIMEOUT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic          wr_sel,
  input  logic [AW-1:0] wr_addr,
  input  logic [IW-1:0] wr_data,
  input  logic          start,
  input  logic [1:0]    mode,
  output logic          enable,
  output logic [IW-1:0] data_x,
  output logic [IW-1:0] data_y,
  output logic          busy,
  output logic          done,
  output logic [1:0]    result
);
  localparam int TW = $clog2(TIMEOUT + 1);
  state_t state, state_n;
  logic [AW-1:0] cnt, raddr;
  logic [TW-1:0] tcnt;
  logic [IW-1:0] rd_x, rd_y;
  // fetch one word ahead so the registered read lines up with enable
  assign raddr = (state == STREAM) ? cnt + 1'b1 : '0;
  compare1024_opbuf #(.IW(IW), .NWORDS(NWORDS), .AW(AW)) u_buf (
    .clk(clk),
    .we(wr_en && state == IDLE),
    .sel(wr_sel),
    .waddr(wr_addr),
    .wdata(wr_data),
    .raddr(raddr),
    .rd_x(rd_x),
    .rd_y(rd_y)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = (state == IDLE)    ? (start ? STREAM : IDLE) :
              (state == STREAM)  ? ((cnt == AW'(NWORDS - 1)) ? CAPTURE : STREAM) :
              (state == CAPTURE) ? ((mode != MODE_NONE || tcnt == TW'(TIMEOUT - 1)) ? DONE : CAPTURE) :
                                   IDLE;
  end
  // on timeout mode is still MODE_NONE, so latching mode yields the timeout code
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      tcnt <= '0;
      result <= MODE_NONE;
    end else begin
      cnt <= (state == STREAM) ? cnt + 1'b1 : '0;
      tcnt <= (state == CAPTURE) ? tcnt + 1'b1 : '0;
      if (state == CAPTURE && state_n == DONE) result <= mode;
    end
  end
  always_comb begin
    enable = state == STREAM || state == CAPTURE;
    busy = enable;
    done = state == DONE;
    data_x = (state == STREAM) ? rd_x : '0;
    data_y = (state == STREAM) ? rd_y : '0;
  end
endmodule

// File: doc/compare1024_feeder.md
Name: compare1024_feeder

Overview:
- Upstream stage of the 1024-bit magnitude comparator inside the FPGA fabric of the SoC system.
- Software writes two 1024-bit operands (X, Y) as 32 words each into local buffers through a simple write port.
- On start, the block drives the comparator's enable and streams the operands one word pair per clock, least-significant word first.
- It captures the comparator's 2-bit mode result, holds it, and pulses done.

Parameters:
- iW, 32, word width streamed to the comparator.
- NWORDS, 32, words per operand; 1024/iW.
- AW, 5, word address width; clog2(NWORDS).
- TIMEOUT, 4, max cycles to wait in CAPTURE for a non-zero comparator mode.

Ports:
- iClk  in  1  system clock; all logic on rising edge.
- iReset  in  1  asynchronous, active-high reset.
- iWrEn  in  1  operand word write strobe.
- iWrSel  in  1  0 = write X buffer, 1 = write Y buffer.
- iWrAddr  in  AW  word index; 0 = least-significant word.
- iWrData  in  iW  word to write.
- iStart  in  1  single-cycle start request.
- iMode  in  2  comparator result (00 not ready, 10 X<Y, 01 X>Y, 11 equal).
- oEnable  out  1  comparator enable.
- oDataX  out  iW  X word to comparator.
- oDataY  out  iW  Y word to comparator.
- oBusy  out  1  high from accepted start until done.
- oDone  out  1  one-cycle pulse when the result is valid.
- oResult  out  2  latched result, same encoding as iMode; 00 = timeout.

Behaviour:
- Reset (async, active-high):
  - State = IDLE; all outputs = 0; word counter = 0; timeout counter = 0.
  - Buffer contents are not reset; they are undefined until written.
- Writes:
  - When iWrEn=1 and state=IDLE, iWrData is written to buffer[iWrSel][iWrAddr] on the clock edge.
  - Writes in any other state are discarded without error.
- FSM:
  - IDLE: iStart=1 -> STREAM, with counter = 0. The start cycle itself does not drive oEnable.
  - STREAM:
    - oEnable=1; oDataX/oDataY = buffer word[counter], presented in the same cycle as oEnable.
    - counter increments each cycle.
    - After the cycle with counter = NWORDS-1 -> CAPTURE.
    - Word 0 therefore coincides with the comparator's first enabled cycle (its internal step 0).
  - CAPTURE:
    - oEnable stays 1; oDataX/oDataY = 0.
    - In the first cycle where iMode != 00: oResult <= iMode, then -> DONE.
    - Otherwise the timeout counter increments; when it reaches TIMEOUT: oResult <= 00, then -> DONE.
  - DONE: oEnable=0, oDone=1 for exactly one cycle, oBusy=0 in this cycle -> IDLE.
- oBusy = 1 in STREAM and CAPTURE only.
- Latency: from the iStart edge, NWORDS+2 cycles to oDone in the normal case (34 with defaults).
- oResult holds its value until the next capture. It is not cleared by start.
- Simultaneous events:
  - iStart while busy: ignored.
  - iStart and iWrEn in the same IDLE cycle: the write is performed and the start is accepted. Streaming reads the buffers from the next cycle, so the written word is included.
- Data path: buffer reads are registered. Read address = next counter value, so registered data aligns with oEnable; no bubble between words.
- oEnable deasserts for at least one cycle (DONE) between operations, so the comparator step counter is cleared before every compare.
- Reset mid-operation: returns immediately to IDLE with oEnable=0. The comparator is thereby reset through its enable.

Decomposition:
- Shared package: state encoding (IDLE, STREAM, CAPTURE, DONE); mode constants MODE_NONE=2'b00, MODE_XLT=2'b10, MODE_XGT=2'b01, MODE_EQ=2'b11; NWORDS and AW derivation.
- One sub-module: compare1024_opbuf, a 2x(NWORDS x iW) simple dual-port buffer with one write port and a registered dual read (X and Y words at the same address). It infers M10K.

Test Plan:
- Load X=Y=all words 0x0000_0001, start -> oEnable high for 33 cycles, words 0..31 in order; oDone at cycle 34; oResult=11.
- X word31=0x8000_0000, Y word31=0x7FFF_FFFF, other words equal -> oResult=01; a lower-word difference (X word0=0, Y word0=5) combined with this still gives 01, because the most-significant word wins.
- X word5=3, Y word5=9, all other words equal -> oResult=10; oBusy high for exactly 33 cycles.
- Tie iMode=00 -> oDone after STREAM plus TIMEOUT cycles; oResult=00.
- Pulse iStart again during STREAM -> ignored, single oDone. Write during STREAM -> buffer unchanged; a second compare returns the same result.
- Assert iReset at STREAM counter=10 -> oEnable, oBusy, oDone immediately 0. A fresh start after release completes with the correct result.
